// File: rtl/window_feed_ctrl_pkg.sv
// Shared feature-loader definitions: controller states, memory read latency
// and the column/row address width helpers.
package window_feed_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } wfc_state_e;

  localparam int MEM_LATENCY = 1;

  function automatic int wfcColWidth(input int maxWidth);
    int w;
    w = $clog2(maxWidth + 2);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int wfcRowWidth(input int maxHeight);
    int w;
    w = $clog2(maxHeight);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/window_feed_ctrl_window_counter.sv
// Landed-column counter for one window row: tracks n, applies the stride test
// and presents the window coordinates until the consumer accepts them.
module wfc_window_counter
  import window_feed_ctrl_pkg::*;
#(
  parameter int kernelWidth = 3,
  parameter int colW        = 9,
  parameter int rowW        = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_abort,
  input  logic            i_colDone,
  input  logic            i_rowEnd,
  input  logic            i_accept,
  input  logic [1:0]      i_stride,
  input  logic [rowW-1:0] i_rowIdx,
  output logic            o_nextHit,
  output logic            o_winValid,
  output logic [colW-1:0] o_winCol,
  output logic [rowW-1:0] o_winRow
);

  logic [colW:0]   r_n;
  logic [colW:0]   w_nInc;
  logic [1:0]      r_phase;
  logic [colW-1:0] r_colCnt;
  logic            w_reached;

  // r_phase counts columns left until the next stride-aligned window, so the
  // hit test needs no divider; r_colCnt is the running (n-K)/S.
  assign w_nInc    = r_n + (colW+1)'(1);
  assign w_reached = w_nInc >= (colW+1)'(kernelWidth);
  assign o_nextHit = w_reached && (r_phase == 2'd0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_n        <= '0;
      r_phase    <= '0;
      r_colCnt   <= '0;
      o_winValid <= 1'b0;
      o_winCol   <= '0;
      o_winRow   <= '0;
    end else if (i_abort) begin
      r_n        <= '0;
      r_phase    <= '0;
      r_colCnt   <= '0;
      o_winValid <= 1'b0;
      o_winCol   <= '0;
      o_winRow   <= '0;
    end else begin
      if (o_winValid && i_accept) begin
        o_winValid <= 1'b0;
      end
      if (i_colDone) begin
        if (o_nextHit) begin
          o_winValid <= 1'b1;
          o_winCol   <= r_colCnt;
          o_winRow   <= i_rowIdx;
        end
        if (i_rowEnd) begin
          r_n      <= '0;
          r_phase  <= '0;
          r_colCnt <= '0;
        end else begin
          r_n <= w_nInc;
          if (o_nextHit) begin
            r_phase  <= i_stride - 2'd1;
            r_colCnt <= r_colCnt + colW'(1);
          end else if (w_reached) begin
            r_phase <= r_phase - 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/window_feed_ctrl.sv
// Sequences feature-memory reads into K row feeders and hands out KxK windows.
// Define WFC_ZERO_PAD_EN to add a zero pad column on each side of every row.
module window_feed_ctrl
  import window_feed_ctrl_pkg::*;
#(
  parameter int kernelWidth = 3,
  parameter int maxWidth    = 256,
  parameter int maxHeight   = 256,
  localparam int colW = wfcColWidth(maxWidth),
  localparam int rowW = wfcRowWidth(maxHeight)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [colW-1:0]        cfg_width_i,
  input  logic [rowW-1:0]        cfg_height_i,
  input  logic [1:0]             cfg_stride_i,
  output logic                   rd_en_o,
  output logic [rowW-1:0]        rd_row_o,
  output logic [colW-1:0]        rd_col_o,
  output logic [kernelWidth-1:0] load_o,
  output logic                   pad_o,
  output logic                   win_valid_o,
  input  logic                   win_ready_i,
  output logic [rowW-1:0]        win_row_o,
  output logic [colW-1:0]        win_col_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int kW = (kernelWidth > 1) ? $clog2(kernelWidth) : 1;
  localparam logic [kW-1:0] lastK = kW'(kernelWidth - 1);

  wfc_state_e             r_state, w_stateNext;
  logic [colW-1:0]        r_width;
  logic [rowW-1:0]        r_height;
  logic [1:0]             r_stride;
  logic [colW-1:0]        r_col, w_colNext;
  logic [rowW-1:0]        r_r0, w_r0Next;
  logic [kW-1:0]          r_k, w_kNext;
  logic                   r_frameEnd, w_frameEndNext;
  logic [kernelWidth-1:0] r_load;
  logic                   r_rowEndLand;
  logic [rowW-1:0]        r_landRow;
  logic [colW:0]          w_weff, w_weffCfg;
  logic                   w_issue, w_slotPad, w_lastSlot, w_lastCol, w_lastRow;
  logic                   w_nextHit, w_accept, w_startOk, w_startTake;

`ifdef WFC_ZERO_PAD_EN
  logic r_pad;

  assign w_weff    = {1'b0, r_width} + (colW+1)'(2);
  assign w_weffCfg = {1'b0, cfg_width_i} + (colW+1)'(2);
  assign w_slotPad = (r_col == '0) || ({1'b0, r_col} == w_weff - (colW+1)'(1));
  assign rd_col_o  = rd_en_o ? (r_col - colW'(1)) : '0;
  assign pad_o     = r_pad;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pad <= 1'b0;
    end else begin
      r_pad <= w_issue && w_slotPad;
    end
  end
`else
  assign w_weff    = {1'b0, r_width};
  assign w_weffCfg = {1'b0, cfg_width_i};
  assign w_slotPad = 1'b0;
  assign rd_col_o  = rd_en_o ? r_col : '0;
  assign pad_o     = 1'b0;
`endif

  // Bounds are compared at widened precision so r0+S+K never wraps.
  assign w_lastSlot = (r_k == lastK);
  assign w_lastCol  = ({1'b0, r_col} == w_weff - (colW+1)'(1));
  assign w_lastRow  = ((rowW+2)'(r_r0) + (rowW+2)'(r_stride) + (rowW+2)'(kernelWidth))
                      > (rowW+2)'(r_height);
  assign w_startOk  = (w_weffCfg >= (colW+1)'(kernelWidth)) &&
                      ((rowW+1)'(cfg_height_i) >= (rowW+1)'(kernelWidth));
  assign w_startTake = (r_state == IDLE) && start_i && !abort_i;

  assign w_issue  = (r_state == ROW) && !abort_i;
  assign rd_en_o  = w_issue && !w_slotPad;
  assign rd_row_o = rd_en_o ? (r_r0 + rowW'(r_k)) : '0;
  assign load_o   = r_load;
  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == DONE) && !abort_i;
  assign w_accept = win_valid_o && win_ready_i;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_stride     <= '0;
      r_col        <= '0;
      r_r0         <= '0;
      r_k          <= '0;
      r_frameEnd   <= 1'b0;
      r_load       <= '0;
      r_rowEndLand <= 1'b0;
      r_landRow    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_col      <= w_colNext;
      r_r0       <= w_r0Next;
      r_k        <= w_kNext;
      r_frameEnd <= w_frameEndNext;
      if (w_startTake) begin
        r_width  <= cfg_width_i;
        r_height <= cfg_height_i;
        r_stride <= (cfg_stride_i == 2'd0) ? 2'd1 : cfg_stride_i;
      end
      r_load       <= w_issue ? (kernelWidth'(1) << r_k) : '0;
      r_rowEndLand <= w_issue && w_lastSlot && w_lastCol;
      if (abort_i || w_startTake) begin
        r_landRow <= '0;
      end else if (r_rowEndLand) begin
        r_landRow <= r_landRow + rowW'(1);
      end
    end
  end

  // A window-completing column parks the FSM in WAIT until that window is taken.
  always_comb begin
    w_stateNext    = r_state;
    w_colNext      = r_col;
    w_r0Next       = r_r0;
    w_kNext        = r_k;
    w_frameEndNext = r_frameEnd;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_colNext      = '0;
          w_r0Next       = '0;
          w_kNext        = '0;
          w_frameEndNext = 1'b0;
          w_stateNext    = w_startOk ? ROW : DONE;
        end
      end
      ROW: begin
        if (!w_lastSlot) begin
          w_kNext = r_k + kW'(1);
        end else begin
          w_kNext = '0;
          if (w_lastCol) begin
            w_colNext      = '0;
            w_r0Next       = r_r0 + rowW'(r_stride);
            w_frameEndNext = w_lastRow;
          end else begin
            w_colNext = r_col + colW'(1);
          end
          if (w_nextHit) begin
            w_stateNext = WAIT;
          end else if (w_lastCol && w_lastRow) begin
            w_stateNext = DONE;
          end
        end
      end
      WAIT: begin
        if (w_accept) begin
          w_stateNext = r_frameEnd ? DONE : ROW;
        end
      end
      DONE: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    if (abort_i) begin
      w_stateNext = IDLE;
    end
  end

  wfc_window_counter #(
    .kernelWidth(kernelWidth),
    .colW       (colW),
    .rowW       (rowW)
  ) u_winCounter (
    .clk       (clk),
    .nrst      (nrst),
    .i_abort   (abort_i),
    .i_colDone (r_load[kernelWidth-1]),
    .i_rowEnd  (r_rowEndLand),
    .i_accept  (win_ready_i),
    .i_stride  (r_stride),
    .i_rowIdx  (r_landRow),
    .o_nextHit (w_nextHit),
    .o_winValid(win_valid_o),
    .o_winCol  (win_col_o),
    .o_winRow  (win_row_o)
  );

endmodule
